// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I datapath: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// the datapath strobes. Memory waits are bounded by WAIT_MAX; illegal opcodes and timeouts park it in HALT.
module multicycle_controller #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic [2:0] state,
    output logic       illegal,
    output logic       timeout
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // The access that would make WAIT_MAX consecutive wait cycles is the last one allowed.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);
    localparam logic [3:0] WAIT_CAP  = 4'(WAIT_MAX);

    logic [2:0] state_q, state_d;
    logic [3:0] waitCnt_q, waitCnt_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;

    logic isLegal, isLoad, isStore, isBranch, isJal, isJalr, badBranch;
    logic memPhase, waitExpired;

    always_comb begin
        isLegal = 1'b0;
        case (opcode)
            OP_LOAD, OP_OPIMM, OP_OP, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: isLegal = 1'b1;
            default:                           isLegal = 1'b0;
        endcase
        isLoad    = (opcode == OP_LOAD);
        isStore   = (opcode == OP_STORE);
        isBranch  = (opcode == OP_BRANCH);
        isJal     = (opcode == OP_JAL);
        isJalr    = (opcode == OP_JALR);
        badBranch = isBranch && ((funct3 == 3'b010) || (funct3 == 3'b011));
    end

    always_comb begin
        memPhase    = (state_q == FETCH) || (state_q == MEM);
        waitExpired = memPhase && !mem_ready && (waitCnt_q == WAIT_LAST);
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            FETCH: begin
                if (mem_ready) begin
                    state_d = DECODE;
                end else if (waitExpired) begin
                    state_d   = HALT;
                    timeout_d = 1'b1;
                end
            end
            DECODE: begin
                if (isLegal) begin
                    state_d = EXEC;
                end else begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end
            end
            EXEC: begin
                if (isLoad || isStore) begin
                    state_d = MEM;
                end else if (isBranch) begin
                    if (badBranch) begin
                        state_d   = HALT;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    state_d = isStore ? FETCH : WB;
                end else if (waitExpired) begin
                    state_d   = HALT;
                    timeout_d = 1'b1;
                end
            end
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Counter only runs while a memory access is stalled in place; any completion or exit clears it.
    always_comb begin
        waitCnt_d = 4'd0;
        if (memPhase && !mem_ready && (state_d == state_q)) begin
            waitCnt_d = (waitCnt_q == WAIT_CAP) ? waitCnt_q : waitCnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            waitCnt_q <= 4'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_src  = PC_PLUS4;
        reg_we  = 1'b0;
        wb_sel  = WB_ALU;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            EXEC: begin
                if (isBranch && !badBranch) begin
                    pc_we  = 1'b1;
                    pc_src = branch_taken ? PC_TARGET : PC_PLUS4;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = isStore;
                pc_we   = isStore && mem_ready;
            end
            WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                if (isJal) begin
                    wb_sel = WB_PC4;
                    pc_src = PC_TARGET;
                end else if (isJalr) begin
                    wb_sel = WB_PC4;
                    pc_src = PC_JALR;
                end else if (isLoad) begin
                    wb_sel = WB_MEM;
                end
            end
            default: begin
            end
        endcase
        state   = state_q;
        illegal = illegal_q;
        timeout = timeout_q;
        // Reset is synchronous, so the outputs are masked while it is held to keep them quiet.
        if (reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            pc_src  = PC_PLUS4;
            reg_we  = 1'b0;
            wb_sel  = WB_ALU;
            state   = FETCH;
            illegal = 1'b0;
            timeout = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: a phase-level instruction model queues per-cycle expected outputs while a
// separate monitor pops and compares them against the controller on every falling edge.
module tb_multicycle_controller;

    localparam int WAIT_MAX = 15;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [2:0] state;
        logic       memReq;
        logic       memWe;
        logic       irWe;
        logic       pcWe;
        logic [1:0] pcSrc;
        logic       regWe;
        logic [1:0] wbSel;
        logic       illegal;
        logic       timeout;
    } outVec_t;

    typedef struct packed {
        logic       rst;
        logic       ready;
        logic       taken;
        logic [6:0] op;
        logic [2:0] f3;
        outVec_t    exp;
    } item_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, ir_we, pc_we, reg_we, illegal, timeout;
    logic [1:0] pc_src, wb_sel;
    logic [2:0] state;

    multicycle_controller #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel), .state(state),
        .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    item_t      plan[$];
    outVec_t    expQ[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         cycleNo    = 0;
    logic [6:0] curOp = 7'd0;
    logic [2:0] curF3 = 3'd0;
    logic [6:0] legalOps [9] = '{LOAD, OPIMM, OP, STORE, BRANCH, JAL, JALR, LUI, AUIPC};

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outVec_t ov(input logic [2:0] st, input logic mreq, input logic mwe,
                                   input logic irw, input logic pcw, input logic [1:0] psrc,
                                   input logic rw, input logic [1:0] wbs, input logic ill,
                                   input logic to);
        return {st, mreq, mwe, irw, pcw, psrc, rw, wbs, ill, to};
    endfunction

    function automatic bit isLegalOp(input logic [6:0] op);
        return op inside {LOAD, OPIMM, OP, STORE, BRANCH, JAL, JALR, LUI, AUIPC};
    endfunction

    task automatic addCycle(input logic rst, input logic rdy, input logic tkn, input outVec_t e);
        item_t it;
        it.rst   = rst;
        it.ready = rdy;
        it.taken = tkn;
        it.op    = curOp;
        it.f3    = curF3;
        it.exp   = e;
        plan.push_back(it);
    endtask

    task automatic addReset(input int n);
        repeat (n) addCycle(1'b1, rbit(), rbit(), '0);
    endtask

    task automatic addHalt(input int kind, input int n);
        repeat (n) addCycle(1'b0, rbit(), rbit(),
            ov(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, kind == 1, kind == 2));
    endtask

    // One memory access: w stalled cycles, then a ready cycle unless the stall reaches WAIT_MAX.
    task automatic memAccess(input logic [2:0] st, input logic isSt, input int w,
                             input logic irw, input logic pcw, output bit ok);
        int n;
        n  = (w < WAIT_MAX) ? w : WAIT_MAX;
        ok = (w < WAIT_MAX);
        for (int i = 0; i < n; i++)
            addCycle(1'b0, 1'b0, rbit(), ov(st, 1'b1, isSt, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
        if (ok)
            addCycle(1'b0, 1'b1, rbit(), ov(st, 1'b1, isSt, irw, pcw, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
    endtask

    task automatic buildInstr(input logic [6:0] op, input logic [2:0] f3, input logic tkn,
                              input int fw, input int mw, output int haltKind);
        bit         ok;
        logic [1:0] wbs, psrc;
        curOp    = op;
        curF3    = f3;
        haltKind = 0;
        memAccess(3'd0, 1'b0, fw, 1'b1, 1'b0, ok);
        if (!ok) begin haltKind = 2; return; end
        addCycle(1'b0, rbit(), rbit(), ov(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
        if (!isLegalOp(op)) begin haltKind = 1; return; end
        if (op == BRANCH) begin
            if (f3 == 3'b010 || f3 == 3'b011) begin
                addCycle(1'b0, rbit(), tkn, '0 | ov(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
                haltKind = 1;
                return;
            end
            addCycle(1'b0, rbit(), tkn,
                ov(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, tkn ? 2'b01 : 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
            return;
        end
        addCycle(1'b0, rbit(), tkn, ov(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
        if (op == LOAD || op == STORE) begin
            memAccess(3'd3, op == STORE, mw, 1'b0, op == STORE, ok);
            if (!ok) begin haltKind = 2; return; end
            if (op == STORE) return;
        end
        wbs  = (op == JAL || op == JALR) ? 2'b10 : (op == LOAD) ? 2'b01 : 2'b00;
        psrc = (op == JAL) ? 2'b01 : (op == JALR) ? 2'b10 : 2'b00;
        addCycle(1'b0, rbit(), rbit(), ov(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, psrc, 1'b1, wbs, 1'b0, 1'b0));
    endtask

    task automatic applyStimulus();
        item_t it;
        while (plan.size() > 0) begin
            it = plan.pop_front();
            @(posedge clk);
            #1;
            reset        = it.rst;
            mem_ready    = it.ready;
            branch_taken = it.taken;
            opcode       = it.op;
            funct3       = it.f3;
            expQ.push_back(it.exp);
        end
    endtask

    // abortAt >= 0 cuts the instruction after that many cycles and asserts reset there instead.
    task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic tkn,
                            input int fw, input int mw, input int holdN, input int resetN,
                            input int abortAt);
        int start, kind;
        start = plan.size();
        buildInstr(op, f3, tkn, fw, mw, kind);
        if (abortAt >= 0 && abortAt < plan.size() - start) begin
            while (plan.size() > start + abortAt) plan.delete(plan.size() - 1);
            addReset(resetN);
        end else if (kind != 0) begin
            addHalt(kind, holdN);
            addReset(resetN);
        end
        applyStimulus();
    endtask

    task automatic checkOutput(input outVec_t act, input outVec_t e);
        compared++;
        if (act !== e) begin
            mismatched++;
            $display("[TB] FAIL cycle %0d outputs: got st=%0d req=%b we=%b ir=%b pc=%b src=%b rw=%b wb=%b ill=%b to=%b, want st=%0d req=%b we=%b ir=%b pc=%b src=%b rw=%b wb=%b ill=%b to=%b",
                cycleNo, act.state, act.memReq, act.memWe, act.irWe, act.pcWe, act.pcSrc, act.regWe,
                act.wbSel, act.illegal, act.timeout, e.state, e.memReq, e.memWe, e.irWe, e.pcWe,
                e.pcSrc, e.regWe, e.wbSel, e.illegal, e.timeout);
        end
    endtask

    initial begin
        outVec_t e, act;
        forever begin
            @(negedge clk);
            cycleNo++;
            if (expQ.size() > 0) begin
                e   = expQ.pop_front();
                act = {state, mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, wb_sel, illegal, timeout};
                checkOutput(act, e);
            end
        end
    end

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        int         fw, mw, abortAt, waited;
        reset        = 1'b1;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        opcode       = 7'd0;
        funct3       = 3'd0;

        addReset(2);
        applyStimulus();

        runInstr(OPIMM,  3'b000, 1'b0, 0, 0, 0, 1, -1);
        runInstr(LOAD,   3'b010, 1'b0, 3, 0, 0, 1, -1);
        runInstr(BRANCH, 3'b000, 1'b1, 0, 0, 0, 1, -1);
        runInstr(BRANCH, 3'b001, 1'b0, 0, 0, 0, 1, -1);
        runInstr(7'h7F,  3'b000, 1'b0, 0, 0, 10, 2, -1);
        runInstr(STORE,  3'b010, 1'b0, 0, 30, 4, 1, -1);
        runInstr(STORE,  3'b010, 1'b0, 0, 14, 0, 1, -1);
        runInstr(OPIMM,  3'b000, 1'b0, 15, 0, 3, 1, -1);
        runInstr(OPIMM,  3'b000, 1'b0, 14, 0, 0, 1, -1);
        runInstr(BRANCH, 3'b011, 1'b1, 0, 0, 3, 1, -1);
        runInstr(JAL,    3'b000, 1'b0, 1, 0, 0, 1, -1);
        runInstr(JALR,   3'b000, 1'b0, 0, 0, 0, 1, -1);
        runInstr(LUI,    3'b000, 1'b0, 0, 0, 0, 1, -1);
        runInstr(AUIPC,  3'b000, 1'b0, 0, 0, 0, 1, -1);
        runInstr(OP,     3'b000, 1'b0, 2, 0, 0, 1, -1);
        runInstr(LOAD,   3'b010, 1'b0, 0, 6, 0, 2, 5);
        runInstr(OPIMM,  3'b000, 1'b0, 0, 0, 0, 1, -1);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 19) < 18) op = legalOps[$urandom_range(0, 8)];
            else                            op = 7'($urandom);
            f3 = 3'($urandom);
            if ($urandom_range(0, 9) == 0) fw = int'($urandom_range(12, 17));
            else                           fw = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) mw = int'($urandom_range(12, 17));
            else                           mw = int'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) abortAt = int'($urandom_range(0, 6));
            else                            abortAt = -1;
            runInstr(op, f3, rbit(), fw, mw, int'($urandom_range(1, 4)),
                     int'($urandom_range(1, 3)), abortAt);
        end

        waited = 0;
        while (expQ.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #1;
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
